// File: rtl/i2s_format_ctrl.sv
// I2S format detector: measures lrck half-frames in bck cycles, locks onto
// 32/64/128fs and drives mode/locked/mute/resync for the downstream converter.
//
// Ports:
//   bck    - bit clock, the only clock
//   rst    - asynchronous active-high reset
//   lrck   - frame sync (high = channel A)
//   mode   - 00 32fs, 01 64fs, 10 128fs, 11 none
//   locked - format locked
//   mute   - force converter data to zero
//   resync - one-cycle pulse realigning the converter
module i2s_format_ctrl #(
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned UNLOCK_ERRS = 2
) (
  input  logic       bck,
  input  logic       rst,
  input  logic       lrck,
  output logic [1:0] mode,
  output logic       locked,
  output logic       mute,
  output logic       resync
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    ALIGN,
    LOCKED
  } state_e;

  localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_ERRS);

  state_e     state_q, state_d;
  logic       lrck_q;
  logic [7:0] cnt_q, cnt_d;
  logic       first_q, first_d;
  logic [1:0] cand_q, cand_d;
  logic [3:0] match_q, match_d;
  logic [3:0] err_q, err_d;
  logic [1:0] mode_q, mode_d;
  logic       locked_q, locked_d;
  logic       mute_q, mute_d;
  logic       resync_q, resync_d;

  logic       lr_edge;
  logic       lr_rise;
  logic       timeout;
  logic       classed;
  logic       cls_ok;
  logic [1:0] cls;

  assign lr_edge = lrck ^ lrck_q;
  assign lr_rise = lrck & ~lrck_q;
  assign timeout = (cnt_q == 8'hFF);
  assign classed = lr_edge & ~first_q;

  // Half-frame length is cnt_q + 1 at the edge.
  always_comb begin
    cls_ok = 1'b1;
    cls    = 2'b11;
    unique case (1'b1)
      (cnt_q == 8'd15): cls = 2'b00;
      (cnt_q == 8'd31): cls = 2'b01;
      (cnt_q == 8'd63): cls = 2'b10;
      default:          cls_ok = 1'b0;
    endcase
  end

  always_comb begin
    if (lr_edge)
      cnt_d = 8'd0;
    else if (timeout)
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    match_d = match_q;
    err_d   = err_q;
    first_d = first_q & ~lr_edge;
    if (timeout) begin
      state_d = SEARCH;
      match_d = 4'd0;
      err_d   = 4'd0;
      // An edge coinciding with the timeout already starts
      // the fresh measurement.
      first_d = ~lr_edge;
    end else if (classed) begin
      unique case (state_q)
        SEARCH: begin
          if (cls_ok) begin
            cand_d  = cls;
            match_d = 4'd1;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (!cls_ok) begin
            state_d = SEARCH;
            match_d = 4'd0;
          end else if (cls == cand_q) begin
            if (match_q != 4'hF)
              match_d = match_q + 4'd1;
            if (match_d >= LOCK_N)
              state_d = ALIGN;
          end else begin
            cand_d  = cls;
            match_d = 4'd1;
          end
        end
        ALIGN: begin
          if (!cls_ok || cls != cand_q) begin
            state_d = SEARCH;
            match_d = 4'd0;
          end else if (lr_rise) begin
            state_d = LOCKED;
            match_d = 4'd0;
            err_d   = 4'd0;
          end
        end
        LOCKED: begin
          if (cls_ok && cls == cand_q) begin
            err_d = 4'd0;
          end else begin
            if (err_q != 4'hF)
              err_d = err_q + 4'd1;
            if (err_d >= UNLOCK_N) begin
              state_d = SEARCH;
              err_d   = 4'd0;
              match_d = 4'd0;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_comb begin
    locked_d = (state_d == LOCKED);
    mute_d   = ~locked_d;
    mode_d   = locked_d ? cand_d : 2'b11;
    resync_d = (state_q == ALIGN) && (state_d == LOCKED);
  end

  always_ff @(posedge bck or posedge rst) begin
    if (rst) begin
      state_q  <= SEARCH;
      lrck_q   <= 1'b0;
      cnt_q    <= 8'd0;
      first_q  <= 1'b1;
      cand_q   <= 2'b11;
      match_q  <= 4'd0;
      err_q    <= 4'd0;
      mode_q   <= 2'b11;
      locked_q <= 1'b0;
      mute_q   <= 1'b1;
      resync_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lrck_q   <= lrck;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      cand_q   <= cand_d;
      match_q  <= match_d;
      err_q    <= err_d;
      mode_q   <= mode_d;
      locked_q <= locked_d;
      mute_q   <= mute_d;
      resync_q <= resync_d;
    end
  end

  assign mode   = mode_q;
  assign locked = locked_q;
  assign mute   = mute_q;
  assign resync = resync_q;

endmodule

// File: doc/i2s_format_ctrl.md
I2S_FORMAT_CTRL -- requirements
Module: i2s_format_ctrl

Interface
REQ-001 Parameter LOCK_FRAMES, default 4: number of consecutive matching half-frames needed to declare lock (range 2..15).
REQ-002 Parameter UNLOCK_ERRS, default 2: number of consecutive mismatching half-frames that drops lock (range 1..15).
REQ-003 bck  input  1  sole clock; all logic on posedge bck.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 lrck  input  1  frame sync; high = channel A, low = channel B.
REQ-006 mode  output  2  detected format: 00 = 32fs, 01 = 64fs, 10 = 128fs, 11 = none/unlocked.
REQ-007 locked  output  1  high while the format is locked.
REQ-008 mute  output  1  high to force the downstream converter's data output to 0.
REQ-009 resync  output  1  one-cycle pulse; clears the converter's bit counter and bck divider phase.

Function
REQ-010 The block SHALL register lrck once (lrck_q); edge = (lrck != lrck_q) in the current cycle.
REQ-011 An 8-bit counter SHALL clear to 0 on an edge cycle, increment otherwise, and saturate at 255.
REQ-012 At each edge, half-frame length L = counter+1 SHALL be classified as: L=16 -> 00, L=32 -> 01, L=64 -> 10, any other L -> INVALID.
REQ-013 The first edge after reset or after a timeout SHALL only start measurement and SHALL NOT be classified.
REQ-014 States SHALL be SEARCH, VERIFY, ALIGN and LOCKED; the reset state is SEARCH.
REQ-015 SEARCH, classified edge: a valid class loads cand, sets match=1 and moves to VERIFY; INVALID stays in SEARCH.
REQ-016 VERIFY, edge: class==cand increments match; class!=cand (valid) reloads cand with match=1; INVALID returns to SEARCH.
REQ-017 VERIFY: when match reaches LOCK_FRAMES, the FSM SHALL move to ALIGN in the same cycle.
REQ-018 ALIGN: on the next lrck rising edge (lrck=1, lrck_q=0), the FSM SHALL set mode=cand, locked=1 and mute=0, assert resync for exactly that one cycle, and enter LOCKED.
REQ-019 ALIGN: a mismatching or INVALID classified edge SHALL return to SEARCH.
REQ-020 LOCKED, edge: class==mode clears err; otherwise err increments.
REQ-021 LOCKED: when err reaches UNLOCK_ERRS, the FSM SHALL go to SEARCH in that cycle with mode=11, locked=0, mute=1.
REQ-022 In any state, counter saturation (255) SHALL act as a timeout: go to SEARCH, mode=11, locked=0, mute=1, and re-arm the first-edge rule.
REQ-023 mode SHALL read 11 and mute SHALL read 1 in every state except LOCKED.
REQ-024 resync SHALL never be high for two consecutive cycles and SHALL only assert on the ALIGN->LOCKED transition.
REQ-025 All outputs SHALL be registered; no output depends combinationally on lrck.
REQ-026 match and err SHALL be 4-bit saturating counters.

Reset
REQ-027 While rst is high: state=SEARCH, mode=11, locked=0, mute=1, resync=0, counter=0, match=0, err=0, lrck_q=0, first-edge flag armed.
REQ-028 Reset assertion mid-lock SHALL take effect immediately, without a bck edge.
REQ-029 After deassertion, a full re-lock (REQ-015..018) SHALL be required.

Verification
REQ-030 128fs lrck (64 bck per half): after the first edge plus 4 matching half-frames, at the next lrck rise -> resync pulses 1 cycle, mode=10, locked=1, mute=0.
REQ-031 Locked at 128fs, switch to 64fs -> after 2 mismatching half-frames mode=11, mute=1; then relock with mode=01.
REQ-032 Locked at 64fs, a single half-frame of L=31 followed by L=32 -> err=1 then 0; locked stays 1 and resync does not pulse.
REQ-033 lrck held constant while locked -> at counter=255: locked=0, mode=11, mute=1; the next edge is unclassified.
REQ-034 In VERIFY, L=48 -> return to SEARCH with match cleared; in ALIGN, an L=16 edge with cand=10 -> SEARCH.
REQ-035 rst pulsed asynchronously while locked at 32fs -> all outputs at reset values before the next posedge bck.
